// File: rtl/score_pkg.sv
// Shared types, segment constants and BCD helpers for the score display path.
package score_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } tally_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0-9.
    localparam logic [6:0] SEG7_PATTERNS [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [15:0] bcd_clamp(input logic [15:0] value);
        logic [15:0] result;
        for (int i = 0; i < 4; i++) begin
            result[i*4 +: 4] = (value[i*4 +: 4] > 4'd9) ? 4'd9 : value[i*4 +: 4];
        end
        return result;
    endfunction

    // Ripple-carry BCD increment; 9999 holds instead of wrapping.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        if (value != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (result[i*4 +: 4] == 4'd9) begin
                        result[i*4 +: 4] = 4'd0;
                    end else begin
                        result[i*4 +: 4] = result[i*4 +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_bcd_decoder.sv
// Combinational BCD nibble to active-low seven-segment pattern, with blanking.
module seg7_bcd_decoder
    import score_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_BLANK;
        if (!i_blank && (i_digit <= 4'd9)) begin
            o_seg_n = SEG7_PATTERNS[i_digit];
        end
    end

endmodule

// File: rtl/score_display.sv
// Score display: BCD tally toward the clamped score plus a 4-digit multiplexed
// seven-segment driver. Define SCORE_TALLY_EN to build the counting tally.
module score_display
    import score_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 16,
    parameter int unsigned TALLY_DIV = 20
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] score_in,
    input  logic        game_start,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n,
    output logic [15:0] shown,
    output logic        tally_busy
);

    if ((SCAN_DIV < 1) || (TALLY_DIV < 1)) begin : g_param_check
        $error("score_display: SCAN_DIV and TALLY_DIV must be at least 1");
    end

    logic [15:0] w_target;
    logic [15:0] r_shown;

    assign w_target = bcd_clamp(score_in);
    assign shown    = r_shown;

`ifdef SCORE_TALLY_EN
    tally_state_t         r_state;
    logic [TALLY_DIV-1:0] r_tick_cnt;
    logic                 w_tick;
    logic [15:0]          w_inc;

    assign w_tick     = &r_tick_cnt;
    assign w_inc      = bcd_inc(r_shown);
    assign tally_busy = (r_state == COUNT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_shown    <= '0;
            r_tick_cnt <= '0;
        end else if (game_start) begin
            r_state    <= IDLE;
            r_shown    <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TALLY_DIV'(1);
            if (w_target < r_shown) begin
                r_shown <= w_target;
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_target > r_shown) begin
                            r_state    <= COUNT;
                            r_tick_cnt <= '0;
                        end
                    end
                    COUNT: begin
                        // Target can fall to exactly the shown value; stop rather than overshoot.
                        if (w_target == r_shown) begin
                            r_state <= IDLE;
                        end else if (w_tick) begin
                            r_shown <= w_inc;
                            if (w_inc == w_target) begin
                                r_state <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
`else
    assign tally_busy = 1'b0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_shown <= '0;
        end else if (game_start) begin
            r_shown <= '0;
        end else begin
            r_shown <= w_target;
        end
    end
`endif

    logic [SCAN_DIV+1:0] r_scan_cnt;
    logic [1:0]          w_sel;
    logic [3:0]          w_digit;
    logic [3:0]          w_blank;
    logic [6:0]          w_seg_n;
    logic [6:0]          r_seg_n;
    logic [3:0]          r_an_n;

    assign w_sel   = r_scan_cnt[SCAN_DIV+1:SCAN_DIV];
    assign w_digit = r_shown[{w_sel, 2'b00} +: 4];

    // Leading-zero blanking: a digit blanks only if it and all higher digits are zero.
    assign w_blank[3] = (r_shown[15:12] == 4'd0);
    assign w_blank[2] = (r_shown[11:8] == 4'd0) && w_blank[3];
    assign w_blank[1] = (r_shown[7:4] == 4'd0) && w_blank[2];
    assign w_blank[0] = 1'b0;

    seg7_bcd_decoder u_decoder (
        .i_digit (w_digit),
        .i_blank (w_blank[w_sel]),
        .o_seg_n (w_seg_n)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_scan_cnt <= '0;
            r_an_n     <= 4'b1111;
            r_seg_n    <= SEG_BLANK;
        end else begin
            r_scan_cnt <= r_scan_cnt + (SCAN_DIV + 2)'(1);
            r_an_n     <= w_blank[w_sel] ? 4'b1111 : ~(4'b0001 << w_sel);
            r_seg_n    <= w_seg_n;
        end
    end

    assign an_n  = r_an_n;
    assign seg_n = r_seg_n;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display (SCAN_DIV=2, TALLY_DIV=3); follows SCORE_TALLY_EN.
module tb_score_display;

    localparam int unsigned SCAN_DIV    = 2;
    localparam int unsigned TALLY_DIV   = 3;
    localparam int unsigned TICK        = 1 << TALLY_DIV;
    localparam int unsigned DIGIT_SLOT  = 1 << SCAN_DIV;
    localparam int unsigned SCAN_PERIOD = 4 * DIGIT_SLOT;
    localparam logic [6:0]  SEG_OFF     = 7'b1111111;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic [15:0] score_in = '0;
    logic        game_start = 1'b0;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] shown;
    logic        tally_busy;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [15:0] exp_q[$];
    logic [15:0] prev;
    logic        done;

    score_display #(
        .SCAN_DIV  (SCAN_DIV),
        .TALLY_DIV (TALLY_DIV)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .score_in   (score_in),
        .game_start (game_start),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .shown      (shown),
        .tally_busy (tally_busy)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [15:0] clamp9(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd9 : v[i*4 +: 4];
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return SEG_OFF;
        endcase
    endfunction

    // Sixteen consecutive samples cover every digit slot once, whatever the phase.
    task automatic scan_check(input logic [15:0] val);
        int hi;
        int blank_cnt;
        int idx;
        int cnt [4];
        hi = 0;
        blank_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            if (val[i*4 +: 4] != 4'd0) hi = i;
        end
        for (int c = 0; c < int'(SCAN_PERIOD); c++) begin
            step();
            idx = -1;
            for (int i = 0; i < 4; i++) begin
                if (an_n == ~(4'b0001 << i)) idx = i;
            end
            if (an_n == 4'b1111) begin
                blank_cnt++;
                check_eq("scan_blank_seg", 32'(seg_n), 32'(SEG_OFF));
            end else if (idx < 0) begin
                check_eq("scan_an_onehot", 32'(an_n), 32'hF);
            end else begin
                cnt[idx]++;
                check_eq($sformatf("scan_seg_d%0d", idx), 32'(seg_n),
                         32'(seg_of(val[idx*4 +: 4])));
            end
        end
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("scan_cnt_d%0d", i), cnt[i], (i <= hi) ? DIGIT_SLOT : 0);
        end
        check_eq("scan_blank_cnt", blank_cnt, (3 - hi) * int'(DIGIT_SLOT));
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_an_n"}, 32'(an_n), 32'hF);
        check_eq({tag, "_seg_n"}, 32'(seg_n), 32'(SEG_OFF));
        check_eq({tag, "_shown"}, 32'(shown), 32'h0);
        check_eq({tag, "_busy"}, 32'(tally_busy), 32'h0);
    endtask

    task automatic wait_value(input string tag, input logic [15:0] tgt, input int budget);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            step();
            if (shown == tgt) ok = 1'b1;
        end
        check_eq({tag, "_reached"}, 32'(ok), 32'h1);
    endtask

    initial begin
        #1 Reset_n = 1'b0;
        #1 reset_checks("reset");
        step();
        step();
        Reset_n = 1'b1;
        step();
        scan_check(16'h0000);

`ifdef SCORE_TALLY_EN
        // Tally 0 -> 40: one BCD step per tick, scoreboarded.
        for (int k = 1; k <= 40; k++) exp_q.push_back(to_bcd(k));
        score_in = 16'h0040;
        prev = shown;
        done = 1'b0;
        for (int n = 1; n <= 400 && !done; n++) begin
            step();
            if (n == 1) check_eq("busy_rise", 32'(tally_busy), 32'h1);
            if (shown != prev) begin
                if (exp_q.size() == 0) check_eq("tally_extra", 32'(shown), 32'(prev));
                else check_eq("tally_step", 32'(shown), 32'(exp_q.pop_front()));
                check_eq("tally_phase", (n - 1) % TICK, 0);
                prev = shown;
                if (shown == 16'h0040) begin
                    check_eq("tally_busy_end", 32'(tally_busy), 32'h0);
                    check_eq("tally_cycles", n - 1, 40 * TICK);
                    done = 1'b1;
                end
            end
        end
        check_eq("tally_done", 32'(done), 32'h1);
        check_eq("tally_q_empty", exp_q.size(), 0);

        // Invalid nibble clamps to 9; tally stops at 0x95.
        score_in = 16'h00A5;
        wait_value("clamp", 16'h0095, 60 * TICK);
        repeat (2 * TICK) step();
        check_eq("clamp_hold", 32'(shown), 32'h0095);
        check_eq("clamp_busy", 32'(tally_busy), 32'h0);

        score_in = 16'h0080;
        step();
        check_eq("snap_idle_val", 32'(shown), 32'h0080);
        check_eq("snap_idle_busy", 32'(tally_busy), 32'h0);
        scan_check(16'h0080);

        game_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("gs_shown", 32'(shown), 32'h0);
            check_eq("gs_busy", 32'(tally_busy), 32'h0);
        end
        game_start = 1'b0;
        step();
        check_eq("gs_release_busy", 32'(tally_busy), 32'h1);
        check_eq("gs_release_shown", 32'(shown), 32'h0);

        wait_value("count_to_25", 16'h0025, 30 * TICK);
        score_in = 16'h0010;
        step();
        check_eq("snap_count_val", 32'(shown), 32'h0010);
        check_eq("snap_count_busy", 32'(tally_busy), 32'h0);

        score_in = 16'h0050;
        repeat (4) step();
        #2 Reset_n = 1'b0;
        #1 reset_checks("midreset");
        Reset_n = 1'b1;
        step();
        check_eq("rst_restart_busy", 32'(tally_busy), 32'h1);
        repeat (TICK - 1) step();
        check_eq("rst_first_wait", 32'(shown), 32'h0);
        step();
        check_eq("rst_first_inc", 32'(shown), 32'h0001);
`else
        // Without the tally, shown follows the clamped score one cycle later.
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: score_in = 16'h0032;
                1: score_in = 16'h00A5;
                2: score_in = 16'h1234;
                3: score_in = 16'hFFFF;
                4: score_in = 16'h0007;
                default: score_in = 16'h9A0B;
            endcase
            exp_q.push_back(clamp9(score_in));
            step();
            check_eq("direct_shown", 32'(shown), 32'(exp_q.pop_front()));
            check_eq("direct_busy", 32'(tally_busy), 32'h0);
        end

        score_in = 16'h1234;
        game_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'h0000);
            step();
            check_eq("gs_shown", 32'(shown), 32'(exp_q.pop_front()));
        end
        game_start = 1'b0;
        exp_q.push_back(16'h1234);
        step();
        check_eq("gs_release", 32'(shown), 32'(exp_q.pop_front()));
        scan_check(16'h1234);

        score_in = 16'h0080;
        step();
        check_eq("direct_80", 32'(shown), 32'h0080);
        scan_check(16'h0080);

        score_in = 16'h1000;
        step();
        scan_check(16'h1000);

        score_in = 16'h0321;
        step();
        #2 Reset_n = 1'b0;
        #1 reset_checks("midreset");
        Reset_n = 1'b1;
        step();
        check_eq("rst_reload", 32'(shown), 32'h0321);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
